// File: rtl/lt24_pkg.sv
// lt24_pkg: ILI9341 command codes, init ROM and writer state encoding
package lt24_pkg;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam int ROM_LEN = 6;
  typedef struct packed {
    logic        is_cmd;
    logic        delay_flag;
    logic [15:0] data;
  } rom_entry_t;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, IDLE, SETWIN, PIXEL, DROP} state_t;
  // sleep-out (then long wait), 16-bit colour, BGR order, display on
  function automatic rom_entry_t init_rom(input logic [2:0] i);
    case (i)
      3'd0:    return '{1'b1, 1'b1, {8'h00, CMD_SLPOUT}};
      3'd1:    return '{1'b1, 1'b0, {8'h00, CMD_COLMOD}};
      3'd2:    return '{1'b0, 1'b0, 16'h0055};
      3'd3:    return '{1'b1, 1'b0, {8'h00, CMD_MADCTL}};
      3'd4:    return '{1'b0, 1'b0, 16'h0008};
      default: return '{1'b1, 1'b0, {8'h00, CMD_DISPON}};
    endcase
  endfunction
endpackage

// File: rtl/lt24_bus_cycle.sv
// lt24_bus_cycle: one 8080-style write word, WRn low WR_LOW clocks then high WR_HIGH clocks
module lt24_bus_cycle #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rs_in,
  input  logic [15:0] data_in,
  output logic        wr_n,
  output logic        rs,
  output logic [15:0] d,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(WR_LOW + WR_HIGH + 1);
  localparam logic [CW-1:0] LAST = CW'(WR_LOW + WR_HIGH);
  logic [CW-1:0] cnt, cnt_n;
  assign busy  = cnt != '0;
  assign done  = cnt == LAST;
  assign cnt_n = (start && !busy) ? CW'(1) : (done || !busy) ? '0 : cnt + 1'b1;
  // phase counter; WRn registered from the next phase so the pin never glitches
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      wr_n <= 1'b1;
      rs   <= 1'b1;
      d    <= '0;
    end else begin
      cnt  <= cnt_n;
      wr_n <= !(cnt_n != '0 && cnt_n <= CW'(WR_LOW));
      if (start && !busy) begin
        rs <= rs_in;
        d  <= data_in;
      end
    end
  end
endmodule

// File: rtl/lt24_pixel_writer.sv
// lt24_pixel_writer: pixel handshake to LT24 write bus; LT24_FRAME_PULSE_EN adds frameDone
module lt24_pixel_writer
  import lt24_pkg::*;
#(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int WR_LOW       = 2,
  parameter int WR_HIGH      = 2,
  parameter int RST_CYCLES   = 500,
  parameter int SLEEP_CYCLES = 6000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        initDone,
  output logic        LT24_CSn,
  output logic        LT24_WRn,
  output logic        LT24_RDn,
  output logic        LT24_RS,
  output logic        LT24_RESETn,
  output logic [15:0] LT24_D,
  output logic        LT24_LCD_ON
`ifdef LT24_FRAME_PULSE_EN
  , output logic      frameDone
`endif
);
  localparam int DW = $clog2((RST_CYCLES > SLEEP_CYCLES ? RST_CYCLES : SLEEP_CYCLES) + 1);
  localparam logic [7:0]  X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
  localparam logic [8:0]  X_LIM  = 9'(WIDTH);
  localparam logic [9:0]  Y_LIM  = 10'(HEIGHT);
  localparam logic [15:0] W_END  = 16'(WIDTH - 1);
  localparam logic [15:0] H_HI   = 16'((HEIGHT - 1) >> 8);
  localparam logic [15:0] H_LO   = 16'((HEIGHT - 1) & 255);
  state_t      state, state_n, dest;
  logic [DW-1:0] dly;
  logic [2:0]  ri;
  logic [3:0]  wi;
  logic [7:0]  cx, px;
  logic [8:0]  cy, py;
  logic [15:0] cd, bus_d;
  logic [16:0] win;
  logic        valid, up, start, bus_rs, busy, done, accept, oor, hit;
  rom_entry_t  rom;
  assign rom         = init_rom(ri);
  assign pixelReady  = state == IDLE || (state == PIXEL && done);
  assign accept      = pixelWrite && pixelReady;
  assign oor         = {1'b0, xAddr} >= X_LIM || {1'b0, yAddr} >= Y_LIM;
  assign hit         = valid && xAddr == px && yAddr == py;
  assign dest        = oor ? DROP : hit ? PIXEL : SETWIN;
  assign initDone    = up;
  assign LT24_LCD_ON = up;
  assign LT24_RDn    = 1'b1;
  lt24_bus_cycle #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) u_bus (
    .clock(clock), .reset(reset), .start(start), .rs_in(bus_rs), .data_in(bus_d),
    .wr_n(LT24_WRn), .rs(LT24_RS), .d(LT24_D), .busy(busy), .done(done)
  );
  // column/page window words, selected by the window word counter
  always_comb begin
    win = {1'b0, 8'h00, CMD_RAMWR};
    case (wi)
      4'd0:       win = {1'b0, 8'h00, CMD_CASET};
      4'd1, 4'd3: win = {1'b1, 16'h0000};
      4'd2:       win = {1'b1, 8'h00, cx};
      4'd4:       win = {1'b1, W_END};
      4'd5:       win = {1'b0, 8'h00, CMD_PASET};
      4'd6:       win = {1'b1, 15'h0000, cy[8]};
      4'd7:       win = {1'b1, 8'h00, cy[7:0]};
      4'd8:       win = {1'b1, H_HI};
      4'd9:       win = {1'b1, H_LO};
      default:    ;
    endcase
  end
  // next state and bus request; a pixel may be accepted in the final cycle of a data word
  always_comb begin
    state_n = state;
    start   = 1'b0;
    bus_rs  = 1'b1;
    bus_d   = cd;
    case (state)
      RST_LOW:  state_n = dly == '0 ? RST_WAIT : RST_LOW;
      RST_WAIT: state_n = dly == '0 ? INIT : RST_WAIT;
      INIT: begin
        start   = dly == '0;
        bus_rs  = !rom.is_cmd;
        bus_d   = rom.data;
        state_n = (done && ri == 3'(ROM_LEN - 1)) ? IDLE : INIT;
      end
      IDLE: state_n = accept ? dest : IDLE;
      SETWIN: begin
        start           = 1'b1;
        {bus_rs, bus_d} = win;
        state_n         = (done && wi == 4'd10) ? PIXEL : SETWIN;
      end
      PIXEL: begin
        start   = 1'b1;
        state_n = done ? (accept ? dest : IDLE) : PIXEL;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, delays, ROM/window counters, captured pixel, raster prediction and pin levels
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RST_LOW;
      dly         <= DW'(RST_CYCLES - 1);
      ri          <= '0;
      wi          <= '0;
      valid       <= 1'b0;
      cx          <= '0;
      cy          <= '0;
      cd          <= '0;
      px          <= '0;
      py          <= '0;
      up          <= 1'b0;
      LT24_CSn    <= 1'b1;
      LT24_RESETn <= 1'b0;
    end else begin
      state       <= state_n;
      dly         <= (state == RST_LOW && dly == '0) ? DW'(SLEEP_CYCLES - 1) :
                     (state == INIT && done && rom.delay_flag) ? DW'(SLEEP_CYCLES) :
                     dly != '0 ? dly - 1'b1 : dly;
      ri          <= (state == INIT && done) ? ri + 1'b1 : ri;
      wi          <= (state == SETWIN && done) ? (wi == 4'd10 ? 4'd0 : wi + 1'b1) : wi;
      up          <= up || state_n == IDLE;
      LT24_CSn    <= state_n == RST_LOW || state_n == RST_WAIT;
      LT24_RESETn <= state_n != RST_LOW;
      if (accept) begin
        cx <= xAddr;
        cy <= yAddr;
        cd <= pixelData;
      end
      if (state == PIXEL && start && !busy) begin
        valid <= 1'b1;
        px    <= cx == X_LAST ? '0 : cx + 1'b1;
        py    <= cx == X_LAST ? (cy == Y_LAST ? '0 : cy + 1'b1) : cy;
      end
    end
  end
`ifdef LT24_FRAME_PULSE_EN
  logic wr_q;
  assign frameDone = state == PIXEL && cx == X_LAST && cy == Y_LAST && LT24_WRn && !wr_q;
  // previous WRn level, to spot the rising edge that latches the last pixel
  always_ff @(posedge clock) begin
    if (reset) wr_q <= 1'b1;
    else wr_q <= LT24_WRn;
  end
`endif
endmodule

// File: tb/tb_lt24_pixel_writer.sv
// tb_lt24_pixel_writer: panel-side word log checked against a raster/window model of the writer
module tb_lt24_pixel_writer;
  localparam int W = 240;
  localparam int H = 320;
  logic        clock = 1'b0, reset = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, initDone, LT24_CSn, LT24_WRn, LT24_RDn, LT24_RS, LT24_RESETn, LT24_LCD_ON;
  logic [15:0] LT24_D;
`ifdef LT24_FRAME_PULSE_EN
  logic        frameDone;
  int          frames = 0;
`endif
  int          checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic        wr_prev = 1'b1;
  logic [16:0] exp_q[$], log_q[$];
  bit          mv = 0;
  int          mx = 0, my = 0;

  always #5 clock = ~clock;

  lt24_pixel_writer #(.WIDTH(W), .HEIGHT(H), .WR_LOW(2), .WR_HIGH(2), .RST_CYCLES(4), .SLEEP_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady), .initDone(initDone), .LT24_CSn(LT24_CSn),
    .LT24_WRn(LT24_WRn), .LT24_RDn(LT24_RDn), .LT24_RS(LT24_RS), .LT24_RESETn(LT24_RESETn),
    .LT24_D(LT24_D), .LT24_LCD_ON(LT24_LCD_ON)
`ifdef LT24_FRAME_PULSE_EN
    , .frameDone(frameDone)
`endif
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic void push_init();
    exp_q.push_back(17'h00011);
    exp_q.push_back(17'h0003A);
    exp_q.push_back(17'h10055);
    exp_q.push_back(17'h00036);
    exp_q.push_back(17'h10008);
    exp_q.push_back(17'h00029);
  endfunction

  // what the panel must see for one accepted pixel, from raster order and window rules
  function automatic void model_pixel(int x, int y, logic [15:0] d);
    if (x >= W || y >= H) return;
    if (!(mv && x == mx && y == my)) begin
      exp_q.push_back({1'b0, 16'h002A});
      exp_q.push_back({1'b1, 16'(x / 256)});
      exp_q.push_back({1'b1, 16'(x % 256)});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'(W - 1)});
      exp_q.push_back({1'b0, 16'h002B});
      exp_q.push_back({1'b1, 16'(y / 256)});
      exp_q.push_back({1'b1, 16'(y % 256)});
      exp_q.push_back({1'b1, 16'((H - 1) / 256)});
      exp_q.push_back({1'b1, 16'((H - 1) % 256)});
      exp_q.push_back({1'b0, 16'h002C});
    end
    exp_q.push_back({1'b1, d});
    mv = 1;
    mx = (x + 1) % W;
    my = (x == W - 1) ? (y + 1) % H : y;
  endfunction

  always @(posedge clock) cyc++;

  // panel model: latch a word on each WRn rise while selected, compare with the model queue
  always @(negedge clock) begin
    if (!wr_prev && LT24_WRn && !LT24_CSn) begin
      log_q.push_back({LT24_RS, LT24_D});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra bus word: got %h expected none", {LT24_RS, LT24_D});
      end else check("bus word", 32'({LT24_RS, LT24_D}), 32'(exp_q.pop_front()));
    end
    wr_prev = LT24_WRn;
`ifdef LT24_FRAME_PULSE_EN
    if (frameDone) frames++;
`endif
  end

  task automatic send(input int x, input int y, input logic [15:0] d);
    int n = 0;
    @(negedge clock);
    xAddr = 8'(x);
    yAddr = 9'(y);
    pixelData = d;
    pixelWrite = 1'b1;
    while (!pixelReady && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!pixelReady) begin
      check("accept timeout", 0, 1);
      pixelWrite = 1'b0;
      return;
    end
    model_pixel(x, y, d);
    @(posedge clock);
    acc_cyc = cyc;
    #1;
    pixelWrite = 1'b0;
    xAddr = 8'h55;
    yAddr = 9'h155;
    pixelData = 16'hDEAD;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clock);
    while (!pixelReady && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(nm, 32'(pixelReady), 1);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!initDone && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("initDone", 32'(initDone), 1);
  endtask

  initial begin
    int n, s, t1;
    repeat (3) @(posedge clock);
    #1;
    check("rst pixelReady", 32'(pixelReady), 0);
    check("rst initDone", 32'(initDone), 0);
    check("rst CSn", 32'(LT24_CSn), 1);
    check("rst WRn", 32'(LT24_WRn), 1);
    check("rst RDn", 32'(LT24_RDn), 1);
    check("rst RS", 32'(LT24_RS), 1);
    check("rst D", 32'(LT24_D), 0);
    check("rst RESETn", 32'(LT24_RESETn), 0);
    check("rst LCD_ON", 32'(LT24_LCD_ON), 0);
`ifdef LT24_FRAME_PULSE_EN
    check("rst frameDone", 32'(frameDone), 0);
`endif
    push_init();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (LT24_RESETn) break;
      n++;
    end
    check("RESETn low clocks", n, 4);
    wait_init();
    @(negedge clock);
    check("LCD_ON after init", 32'(LT24_LCD_ON), 1);
    check("CSn after init", 32'(LT24_CSn), 0);
    check("ready after init", 32'(pixelReady), 1);
    check("init word count", log_q.size(), 6);
    check("init first word", 32'(log_q[0]), 32'h00011);
    check("init last word", 32'(log_q[5]), 32'h00029);

    send(0, 0, 16'hF800);
    @(negedge clock);
    check("ready low after accept", 32'(pixelReady), 0);
    wait_ready("ready after first pixel");
    check("pixel words", log_q.size(), 18);
    check("caset", 32'(log_q[6]), 32'h0002A);
    check("col end", 32'(log_q[10]), 32'h100EF);
    check("row end hi", 32'(log_q[14]), 32'h10001);
    check("row end lo", 32'(log_q[15]), 32'h1003F);
    check("ramwr", 32'(log_q[16]), 32'h0002C);
    check("first data", 32'(log_q[17]), 32'h1F800);

    send(1, 0, 16'h07E0);
    t1 = acc_cyc;
    @(negedge clock);
    check("WRn high in accept cycle", 32'(LT24_WRn), 1);
    @(negedge clock);
    check("WRn low next cycle", 32'(LT24_WRn), 0);
    send(2, 0, 16'h001F);
    check("accept spacing", acc_cyc - t1, 5);
    wait_ready("ready after stream");
    check("stream words", log_q.size(), 20);
    check("stream data", 32'(log_q[19]), 32'h1001F);

    s = log_q.size();
    send(239, 0, 16'h1234);
    send(0, 1, 16'h5678);
    wait_ready("ready after row wrap");
    check("row wrap words", log_q.size(), s + 13);
    check("row wrap data", 32'(log_q[s + 12]), 32'h15678);
    send(10, 5, 16'hABCD);
    wait_ready("ready after jump");
    check("jump x", 32'(log_q[s + 15]), 32'h1000A);
    check("jump y", 32'(log_q[s + 20]), 32'h10005);

    s = log_q.size();
    send(240, 3, 16'hFFFF);
    @(negedge clock);
    check("drop ready low", 32'(pixelReady), 0);
    @(negedge clock);
    check("drop ready back", 32'(pixelReady), 1);
    send(0, 320, 16'hEEEE);
    repeat (8) @(negedge clock);
    check("drop no words", log_q.size(), s);
    send(11, 5, 16'h4321);
    wait_ready("ready after drop");
    check("prediction kept", log_q.size(), s + 1);

    send(239, 319, 16'h0F0F);
    send(0, 0, 16'hF0F0);
    wait_ready("ready after frame wrap");
    check("frame wrap data", 32'(log_q[log_q.size() - 1]), 32'h1F0F0);
    check("frame wrap words", log_q.size(), s + 14);

    s = log_q.size();
    send(50, 60, 16'h2222);
    n = 0;
    while (log_q.size() < s + 2 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("setwin progress", log_q.size(), s + 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid rst WRn", 32'(LT24_WRn), 1);
    check("mid rst CSn", 32'(LT24_CSn), 1);
    check("mid rst RESETn", 32'(LT24_RESETn), 0);
    check("mid rst initDone", 32'(initDone), 0);
    exp_q.delete();
    mv = 0;
    s = log_q.size();
    @(posedge clock);
    #1;
    reset = 1'b0;
    push_init();
    wait_init();
    check("re-init words", log_q.size(), s + 6);
    check("re-init first", 32'(log_q[s]), 32'h00011);
    send(5, 6, 16'h3333);
    wait_ready("ready after re-init pixel");
    check("re-init pixel words", log_q.size(), s + 18);

`ifdef LT24_FRAME_PULSE_EN
    n = frames;
    send(237, 319, 16'h0001);
    send(238, 319, 16'h0002);
    send(239, 319, 16'h0003);
    wait_ready("ready after frame end");
    repeat (3) @(negedge clock);
    check("frameDone pulses", frames - n, 1);
`endif

    repeat (10) @(negedge clock);
    check("model queue drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
